// File: rtl/serial_write_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_write_tx_if
//  Purpose  : Bundles the controller handshake, the block data bus and the
//             UART line of the serial write transmitter.
//  Ports    : SerialWriteEn  controller enable (master -> slave)
//             DataIn         block to send, byte 0 in the top byte
//             Tx             UART line, idle high (slave -> master)
//             SerialWriteRy  transaction complete (slave -> master)
//             Busy           frames being shifted out (slave -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface serial_write_tx_if #(
    parameter int NBYTES = 16
);
    logic                  SerialWriteEn;
    logic [8*NBYTES-1:0]   DataIn;
    logic                  Tx;
    logic                  SerialWriteRy;
    logic                  Busy;

    modport master (
        output SerialWriteEn,
        output DataIn,
        input  Tx,
        input  SerialWriteRy,
        input  Busy
    );

    modport slave (
        input  SerialWriteEn,
        input  DataIn,
        output Tx,
        output SerialWriteRy,
        output Busy
    );
endinterface
`default_nettype wire

// File: rtl/serial_write_tx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_write_tx
//  Purpose  : Serial-write responder. On SerialWriteEn it latches a block of
//             NBYTES bytes and sends it as back-to-back UART 8N1 frames
//             (LSB first, byte 0 = top byte of DataIn), then raises
//             SerialWriteRy until the enable is released.
//  Ports    : Clk                 system clock, rising edge
//             Rst                 synchronous reset, active-high
//             bus (slave)         SerialWriteEn, DataIn in;
//                                 Tx, SerialWriteRy, Busy out
//  Params   : CLKS_PER_BIT        clock cycles per UART bit (>= 2)
//             NBYTES              bytes per block
//  Revision : 1.0  initial release
// ============================================================================
module serial_write_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int NBYTES       = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    serial_write_tx_if.slave  bus
);

    localparam int DATA_W = 8 * NBYTES;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [CNT_W-1:0]  c_BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] c_LAST_BYTE = BYTE_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_baudCnt;
    logic [2:0]          r_bitIdx;
    logic [BYTE_W-1:0]   r_byteIdx;
    logic [DATA_W-1:0]   r_shift;
    logic                r_tx;
    logic                r_ready;
    logic                r_busy;

    // The byte on the wire is always the top byte of the shift register;
    // the register moves up one byte at the end of every stop bit.
    logic [7:0]          w_curByte;
    logic [2:0]          w_nextIdx;
    logic                w_baudEnd;

    assign w_curByte = r_shift[DATA_W-1 -: 8];
    assign w_nextIdx = r_bitIdx + 3'd1;
    assign w_baudEnd = (r_baudCnt == c_BAUD_LAST);

    // Tx holds the level of the bit period that begins after each edge, so
    // every decision below sets the line for the next bit one cycle early.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= S_IDLE;
            r_baudCnt <= '0;
            r_bitIdx  <= '0;
            r_byteIdx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx      <= 1'b1;
                    r_ready   <= 1'b0;
                    r_busy    <= 1'b0;
                    r_baudCnt <= '0;
                    if (bus.SerialWriteEn) begin
                        r_shift   <= bus.DataIn;
                        r_byteIdx <= '0;
                        r_bitIdx  <= '0;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_START;
                    end
                end

                S_START: begin
                    if (w_baudEnd) begin
                        r_baudCnt <= '0;
                        r_bitIdx  <= '0;
                        r_tx      <= w_curByte[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (w_baudEnd) begin
                        r_baudCnt <= '0;
                        if (r_bitIdx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bitIdx <= w_nextIdx;
                            r_tx     <= w_curByte[w_nextIdx];
                        end
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (w_baudEnd) begin
                        r_baudCnt <= '0;
                        if (r_byteIdx == c_LAST_BYTE) begin
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            // Next start bit follows the stop bit directly.
                            r_byteIdx <= r_byteIdx + 1'b1;
                            r_shift   <= r_shift << 8;
                            r_tx      <= 1'b0;
                            r_state   <= S_START;
                        end
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end

                S_DONE: begin
                    // Ready is held until the controller releases the enable,
                    // which also guarantees En is low before a new block.
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (!bus.SerialWriteEn) begin
                        r_ready <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Tx            = r_tx;
    assign bus.SerialWriteRy = r_ready;
    assign bus.Busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_serial_write_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_write_tx
//  Purpose  : Self-checking bench for serial_write_tx. A UART receiver model
//             decodes Tx at mid-bit and compares every byte, frame spacing and
//             ready latency against values derived from the block data.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_write_tx;

    localparam int CPB   = 4;
    localparam int NB    = 16;
    localparam int FRAME = 10 * CPB;
    localparam int BLOCK = NB * FRAME;

    localparam logic [127:0] c_PATTERN = 128'h00112233445566778899AABBCCDDEEFF;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   cyc = 0;

    int   nVec = 0;
    int   nErr = 0;

    serial_write_tx_if #(.NBYTES(NB)) bus ();

    serial_write_tx #(
        .CLKS_PER_BIT (CPB),
        .NBYTES       (NB)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nVec++;
        if (obs !== exp) begin
            nErr++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Expected byte i of a block: byte 0 is the most significant byte.
    function automatic logic [7:0] refByte(input logic [127:0] data, input int i);
        logic [127:0] sh;
        sh = data >> (8 * (NB - 1 - i));
        return sh[7:0];
    endfunction

    task automatic waitFall(output bit ok, output int t);
        ok = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (bus.Tx === 1'b0) begin
                ok = 1'b1;
                t  = cyc;
                return;
            end
            tick(1);
        end
        t = cyc;
    endtask

    task automatic rxFrame(output logic [7:0] b, output bit ok, output int tFall);
        b = 8'h00;
        waitFall(ok, tFall);
        if (!ok) return;
        tick(CPB / 2);
        check("start_bit", bus.Tx, 1'b0);
        check("busy_in_frame", bus.Busy, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick(CPB);
            b[k] = bus.Tx;
        end
        tick(CPB);
        check("stop_bit", bus.Tx, 1'b1);
    endtask

    // Receives one whole block and returns at the first cycle Ry is seen high.
    task automatic rxBlock(input logic [127:0] data, input string tag, output int t0);
        logic [7:0] b;
        bit         ok;
        int         t;
        int         tPrev;
        t0    = cyc;
        tPrev = cyc;
        for (int i = 0; i < NB; i++) begin
            rxFrame(b, ok, t);
            if (!ok) begin
                check({tag, "_frame_timeout"}, 1'b0, 1'b1);
                return;
            end
            check(tag, b, refByte(data, i));
            if (i == 0) t0 = t;
            else        check("frame_spacing", t - tPrev, FRAME);
            tPrev = t;
        end
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (bus.SerialWriteRy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (!ok) begin
            check({tag, "_ry_timeout"}, 1'b0, 1'b1);
            return;
        end
        check("ry_latency", cyc - t0, BLOCK);
        check("done_busy", bus.Busy, 1'b0);
        check("done_tx", bus.Tx, 1'b1);
    endtask

    task automatic checkIdle(input string tag);
        check({tag, "_tx"}, bus.Tx, 1'b1);
        check({tag, "_ry"}, bus.SerialWriteRy, 1'b0);
        check({tag, "_busy"}, bus.Busy, 1'b0);
    endtask

    int   cycEn;
    int   t0;
    int   dropAt;
    bit   sawLow;
    logic [127:0] rnd;

    initial begin
        bus.SerialWriteEn = 1'b0;
        bus.DataIn        = '0;

        // 1. reset and quiet idle
        Rst = 1'b1;
        tick(1);
        checkIdle("reset");
        tick(1);
        Rst = 1'b0;
        tick(5);
        checkIdle("idle_no_en");

        // 2. reference pattern
        bus.DataIn        = c_PATTERN;
        bus.SerialWriteEn = 1'b1;
        cycEn             = cyc;
        rxBlock(c_PATTERN, "byte_pattern", t0);
        check("start_latency", t0 - cycEn, 1);

        // 3. Ry held while En high, released one cycle after En falls
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("ry_hold", bus.SerialWriteRy, 1'b1);
        end
        bus.SerialWriteEn = 1'b0;
        tick(1);
        checkIdle("ry_release");

        // 4. DataIn changes mid-block do not affect the bytes sent
        tick(2);
        bus.DataIn        = c_PATTERN;
        bus.SerialWriteEn = 1'b1;
        fork
            rxBlock(c_PATTERN, "byte_latched", t0);
            begin
                tick(1 + 3 * FRAME + 3 * CPB);
                bus.DataIn = '1;
            end
        join
        bus.SerialWriteEn = 1'b0;
        tick(2);
        checkIdle("after_latched");

        // 5. reset in byte 5, then a fresh block from byte 0
        bus.DataIn        = c_PATTERN;
        bus.SerialWriteEn = 1'b1;
        tick(1 + 5 * FRAME + 3 * CPB);
        check("busy_byte5", bus.Busy, 1'b1);
        Rst               = 1'b1;
        bus.SerialWriteEn = 1'b0;
        tick(1);
        checkIdle("mid_reset");
        Rst = 1'b0;
        tick(2);
        checkIdle("post_reset");
        bus.DataIn        = {16{8'hA5}};
        bus.SerialWriteEn = 1'b1;
        rxBlock({16{8'hA5}}, "byte_a5", t0);
        bus.SerialWriteEn = 1'b0;
        tick(2);
        checkIdle("after_a5");

        // 6. En dropped early: block completes, Ry one cycle, no restart
        rnd               = {$urandom, $urandom, $urandom, $urandom};
        bus.DataIn        = rnd;
        bus.SerialWriteEn = 1'b1;
        fork
            begin
                rxBlock(rnd, "byte_early_drop", t0);
                tick(1);
                check("ry_pulse", bus.SerialWriteRy, 1'b0);
            end
            begin
                tick(100);
                bus.SerialWriteEn = 1'b0;
            end
        join
        sawLow = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(1);
            if (bus.Tx !== 1'b1 || bus.Busy !== 1'b0) sawLow = 1'b1;
        end
        check("no_restart", sawLow, 1'b0);

        // random blocks with random enable hold times
        for (int n = 0; n < 4; n++) begin
            rnd               = {$urandom, $urandom, $urandom, $urandom};
            dropAt            = int'($urandom_range(1, BLOCK + 30));
            bus.DataIn        = rnd;
            bus.SerialWriteEn = 1'b1;
            fork
                rxBlock(rnd, "byte_random", t0);
                begin
                    tick(dropAt);
                    bus.SerialWriteEn = 1'b0;
                end
            join
            tick(2);
            checkIdle("random_end");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire
